// File: rtl/uks_channel_ctrl.sv
// Channel controller for the 16-point OSN/REZ distribution board: debounced address commit,
// break-before-make forward enables and non-revertive OSN/REZ return selection on loss of signal.
module uks_channel_ctrl #(
   parameter int N_CH       = 16,
   parameter int ADDR_W     = 8,
   parameter int STABLE_CYC = 1024,
   parameter int GUARD_CYC  = 16,
   parameter int LOS_CYC    = 50000
) (
   input  logic                     clk_50_MHz,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [N_CH-1:0]          din_osn,
   input  logic [N_CH-1:0]          din_rez,
   output logic [N_CH-1:0]          dout_en,
   output logic                     ret_sel,
   output logic [$clog2(N_CH)-1:0]  ch_sel,
   output logic                     ch_active,
   output logic                     los_osn,
   output logic                     los_rez,
   output logic [7:0]               switch_cnt
);

   localparam int CH_W    = $clog2(N_CH);
   localparam int STAB_W  = $clog2(STABLE_CYC);
   localparam int GUARD_W = $clog2(GUARD_CYC);
   localparam int LOS_W   = $clog2(LOS_CYC + 1);

   localparam logic [STAB_W-1:0]  STAB_MAX   = STAB_W'(STABLE_CYC - 1);
   localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYC - 1);
   localparam logic [LOS_W-1:0]   LOS_MAX    = LOS_W'(LOS_CYC);

   typedef enum logic [1:0] {IDLE, GUARD, RUN_OSN, RUN_REZ} state_e;

   // Address synchronizer, stability counter and committed address
   logic [ADDR_W-1:0]  addr_s1_q, addr_s2_q;
   logic [STAB_W-1:0]  stab_q, stab_d;
   logic               com_vld_q, com_vld_d;
   logic [ADDR_W-1:0]  com_addr_q, com_addr_d;
   logic               addr_chg, commit, new_valid;
   logic [CH_W-1:0]    new_ch;

   // Return-line synchronizers (two flops plus one edge-detect stage)
   logic [N_CH-1:0]    osn_s1_q, osn_s2_q, osn_s3_q;
   logic [N_CH-1:0]    rez_s1_q, rez_s2_q, rez_s3_q;
   logic [N_CH-1:0]    osn_tog_v, rez_tog_v;

   logic [LOS_W-1:0]   osn_cnt_q, osn_cnt_d, rez_cnt_q, rez_cnt_d;
   logic               los_osn_q, los_osn_d, los_rez_q, los_rez_d;

   state_e             state_q, state_d;
   logic [GUARD_W-1:0] guard_q, guard_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [7:0]         swc_q, swc_d, swc_inc;
   logic [N_CH-1:0]    dout_en_q, dout_en_d;
   logic               ret_sel_q, ret_sel_d, active_q, active_d;
   logic               los_clr;

   // The counter clears on the cycle the synchronized address is about to change, so a pin
   // change commits exactly 2+STABLE_CYC edges later.
   assign addr_chg  = (addr_s1_q != addr_s2_q);
   assign commit    = (stab_q == STAB_MAX) && (!com_vld_q || (addr_s2_q != com_addr_q));
   assign new_valid = (addr_s2_q[ADDR_W-1:CH_W] == '0);
   assign new_ch    = addr_s2_q[CH_W-1:0];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      stab_d     = stab_q;
      com_vld_d  = com_vld_q;
      com_addr_d = com_addr_q;
      if (addr_chg)
         stab_d = '0;
      else if (stab_q != STAB_MAX)
         stab_d = stab_q + 1'b1;
      if (commit) begin
         com_vld_d  = 1'b1;
         com_addr_d = addr_s2_q;
      end
   end

   assign osn_tog_v = osn_s2_q ^ osn_s3_q;
   assign rez_tog_v = rez_s2_q ^ rez_s3_q;
   assign swc_inc   = (swc_q == 8'hFF) ? swc_q : swc_q + 8'd1;

   always_comb begin
      state_d = state_q;
      guard_d = guard_q;
      ch_d    = ch_q;
      swc_d   = swc_q;
      los_clr = 1'b0;
      // An address commit outranks any LOS switchover evaluated in the same cycle.
      if (commit && !new_valid) begin
         state_d = IDLE;
      end else if (commit) begin
         state_d = GUARD;
         guard_d = '0;
         ch_d    = new_ch;
         swc_d   = '0;
         los_clr = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: ;
            GUARD:
               if (guard_q == GUARD_LAST) state_d = RUN_OSN;
               else                       guard_d = guard_q + 1'b1;
            RUN_OSN:
               if (los_osn_q && !los_rez_q) begin
                  state_d = RUN_REZ;
                  swc_d   = swc_inc;
               end
            RUN_REZ:
               if (los_rez_q && !los_osn_q) begin
                  state_d = RUN_OSN;
                  swc_d   = swc_inc;
               end
            default: state_d = IDLE;
         endcase
      end
      if (state_d == IDLE) los_clr = 1'b1;
   end

   always_comb begin
      dout_en_d = '0;
      active_d  = (state_d == RUN_OSN) || (state_d == RUN_REZ);
      ret_sel_d = (state_d == RUN_REZ);
      if (active_d) dout_en_d[ch_d] = 1'b1;
   end

   always_comb begin
      osn_cnt_d = osn_cnt_q;
      rez_cnt_d = rez_cnt_q;
      if (los_clr || osn_tog_v[ch_q]) osn_cnt_d = '0;
      else if (osn_cnt_q != LOS_MAX)  osn_cnt_d = osn_cnt_q + 1'b1;
      if (los_clr || rez_tog_v[ch_q]) rez_cnt_d = '0;
      else if (rez_cnt_q != LOS_MAX)  rez_cnt_d = rez_cnt_q + 1'b1;
      los_osn_d = (osn_cnt_d == LOS_MAX);
      los_rez_d = (rez_cnt_d == LOS_MAX);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_50_MHz) begin
      if (rst) begin
         addr_s1_q  <= '0;
         addr_s2_q  <= '0;
         stab_q     <= '0;
         com_vld_q  <= 1'b0;
         com_addr_q <= '0;
         osn_s1_q   <= '0;
         osn_s2_q   <= '0;
         osn_s3_q   <= '0;
         rez_s1_q   <= '0;
         rez_s2_q   <= '0;
         rez_s3_q   <= '0;
         osn_cnt_q  <= '0;
         rez_cnt_q  <= '0;
         los_osn_q  <= 1'b0;
         los_rez_q  <= 1'b0;
         state_q    <= IDLE;
         guard_q    <= '0;
         ch_q       <= '0;
         swc_q      <= '0;
         dout_en_q  <= '0;
         ret_sel_q  <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         addr_s1_q  <= addr;
         addr_s2_q  <= addr_s1_q;
         stab_q     <= stab_d;
         com_vld_q  <= com_vld_d;
         com_addr_q <= com_addr_d;
         osn_s1_q   <= din_osn;
         osn_s2_q   <= osn_s1_q;
         osn_s3_q   <= osn_s2_q;
         rez_s1_q   <= din_rez;
         rez_s2_q   <= rez_s1_q;
         rez_s3_q   <= rez_s2_q;
         osn_cnt_q  <= osn_cnt_d;
         rez_cnt_q  <= rez_cnt_d;
         los_osn_q  <= los_osn_d;
         los_rez_q  <= los_rez_d;
         state_q    <= state_d;
         guard_q    <= guard_d;
         ch_q       <= ch_d;
         swc_q      <= swc_d;
         dout_en_q  <= dout_en_d;
         ret_sel_q  <= ret_sel_d;
         active_q   <= active_d;
      end
   end

   assign dout_en    = dout_en_q;
   assign ret_sel    = ret_sel_q;
   assign ch_sel     = ch_q;
   assign ch_active  = active_q;
   assign los_osn    = los_osn_q;
   assign los_rez    = los_rez_q;
   assign switch_cnt = swc_q;

endmodule

// File: tb/tb_uks_channel_ctrl.sv
// Scoreboard bench for uks_channel_ctrl: expected output snapshots with cycle windows are queued
// by the stimulus; a monitor pops one on every change of the registered output bundle.
module tb_uks_channel_ctrl;

   localparam int L = 3000;   // shortened loss timeout keeps the run short

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  addr;
   logic [15:0] din_osn = '0, din_rez = '0;
   logic [15:0] dout_en;
   logic        ret_sel;
   logic [3:0]  ch_sel;
   logic        ch_active, los_osn, los_rez;
   logic [7:0]  switch_cnt;

   uks_channel_ctrl #(.LOS_CYC(L)) dut (
      .clk_50_MHz (clk),
      .rst        (rst),
      .addr       (addr),
      .din_osn    (din_osn),
      .din_rez    (din_rez),
      .dout_en    (dout_en),
      .ret_sel    (ret_sel),
      .ch_sel     (ch_sel),
      .ch_active  (ch_active),
      .los_osn    (los_osn),
      .los_rez    (los_rez),
      .switch_cnt (switch_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] de;
      logic        rs;
      logic [3:0]  cs;
      logic        ca;
      logic        lo;
      logic        lr;
      logic [7:0]  sc;
   } snap_t;

   typedef struct {
      int    id;
      snap_t v;
      int    lo;
      int    hi;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0, n_err = 0;
   int          cyc = 0, last_tog = 0;
   logic        mon_en = 1'b0;
   logic [15:0] osn_en = '1, rez_en = '1;
   event        tog_ev;

   always @(posedge clk) cyc <= cyc + 1;

   // Every 100 cycles each enabled return line toggles.
   always @(negedge clk) begin
      if (cyc % 100 == 0) begin
         din_osn = din_osn ^ osn_en;
         din_rez = din_rez ^ rez_en;
         last_tog = cyc;
         -> tog_ev;
      end
   end

   snap_t cur, prev;
   logic  have_prev = 1'b0;
   exp_t  got;

   always @(posedge clk) begin
      #2;
      if (mon_en) begin
         cur = {dout_en, ret_sel, ch_sel, ch_active, los_osn, los_rez, switch_cnt};
         if (!have_prev || cur !== prev) begin
            have_prev = 1'b1;
            prev = cur;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
            end else begin
               got = exp_q.pop_front();
               if (cur !== got.v || cyc < got.lo || cyc > got.hi) begin
                  n_err++;
                  $display("FAIL step%0d cyc=%0d window=%0d..%0d got=%h want=%h",
                           got.id, cyc, got.lo, got.hi, cur, got.v);
               end
            end
         end
      end
   end

   task automatic exp_out(input int id, input logic [15:0] de, input logic rs, input logic [3:0] cs,
                          input logic ca, input logic lo_o, input logic lr, input logic [7:0] sc,
                          input int at, input int tol);
      exp_t x;
      x.id = id;
      x.v  = {de, rs, cs, ca, lo_o, lr, sc};
      x.lo = at - tol;
      x.hi = at + tol;
      exp_q.push_back(x);
   endtask

   task automatic drain(input int id, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain%0d pending=%0d cyc=%0d", id, exp_q.size(), cyc);
         exp_q.delete();
      end
   endtask

   initial begin
      #(400000 * 10);
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t, c;
      rst  = 1'b1;
      addr = 8'h05;
      repeat (4) @(negedge clk);

      // Reset state, then commit of 0x05 after 2+1024 cycles and a 16-cycle guard
      t = cyc;
      rst = 1'b0;
      mon_en = 1'b1;
      exp_out(1, 16'h0000, 0, 4'd0, 0, 0, 0, 8'd0, t + 1, 0);
      exp_out(2, 16'h0000, 0, 4'd5, 0, 0, 0, 8'd0, t + 1026, 0);
      exp_out(3, 16'h0020, 0, 4'd5, 1, 0, 0, 8'd0, t + 1042, 0);
      drain(1, 1200);

      // Short glitch to 0x07 must not commit; any output change would be flagged
      @(negedge clk);
      addr = 8'h07;
      repeat (500) @(negedge clk);
      addr = 8'h05;
      repeat (1200) @(negedge clk);

      // OSN stuck: switch to REZ
      @(tog_ev);
      osn_en[5] = 1'b0;
      c = last_tog;
      exp_out(4, 16'h0020, 0, 4'd5, 1, 1, 0, 8'd0, c + L + 3, 2);
      exp_out(5, 16'h0020, 1, 4'd5, 1, 1, 0, 8'd1, c + L + 4, 2);
      drain(2, L + 200);

      // OSN recovers: flag clears but REZ is kept
      @(tog_ev);
      osn_en[5] = 1'b1;
      @(tog_ev);
      c = last_tog;
      exp_out(6, 16'h0020, 1, 4'd5, 1, 0, 0, 8'd1, c + 3, 2);
      drain(3, 50);
      repeat (500) @(negedge clk);

      // REZ stops: back to OSN
      @(tog_ev);
      rez_en[5] = 1'b0;
      c = last_tog;
      exp_out(7, 16'h0020, 1, 4'd5, 1, 0, 1, 8'd1, c + L + 3, 2);
      exp_out(8, 16'h0020, 0, 4'd5, 1, 0, 1, 8'd2, c + L + 4, 2);
      drain(4, L + 200);

      // Both lost: flags set, state and count hold
      @(tog_ev);
      osn_en[5] = 1'b0;
      c = last_tog;
      exp_out(9, 16'h0020, 0, 4'd5, 1, 1, 1, 8'd2, c + L + 3, 2);
      drain(5, L + 200);
      repeat (300) @(negedge clk);

      @(tog_ev);
      osn_en[5] = 1'b1;
      rez_en[5] = 1'b1;
      @(tog_ev);
      c = last_tog;
      exp_out(10, 16'h0020, 0, 4'd5, 1, 0, 0, 8'd2, c + 3, 2);
      drain(6, 50);
      repeat (300) @(negedge clk);

      // Commit of 0x0C lands on the very edge the OSN loss would switch: address wins
      @(tog_ev);
      osn_en[5] = 1'b0;
      c = last_tog;
      exp_out(11, 16'h0020, 0, 4'd5,  1, 1, 0, 8'd2, c + L + 3, 0);
      exp_out(12, 16'h0000, 0, 4'd12, 0, 0, 0, 8'd0, c + L + 4, 0);
      exp_out(13, 16'h1000, 0, 4'd12, 1, 0, 0, 8'd0, c + L + 20, 0);
      while (cyc < c + L - 1022) @(negedge clk);
      addr = 8'h0C;
      drain(7, L + 200);

      // Invalid address: back to IDLE
      @(negedge clk);
      t = cyc;
      addr = 8'h35;
      exp_out(14, 16'h0000, 0, 4'd12, 0, 0, 0, 8'd0, t + 1026, 0);
      drain(8, 1200);

      // Channel 5 again with OSN still stuck, ends in RUN_REZ
      @(negedge clk);
      t = cyc;
      addr = 8'h05;
      exp_out(15, 16'h0000, 0, 4'd5, 0, 0, 0, 8'd0, t + 1026, 0);
      exp_out(16, 16'h0020, 0, 4'd5, 1, 0, 0, 8'd0, t + 1042, 0);
      exp_out(17, 16'h0020, 0, 4'd5, 1, 1, 0, 8'd0, t + 1026 + L, 1);
      exp_out(18, 16'h0020, 1, 4'd5, 1, 1, 0, 8'd1, t + 1027 + L, 1);
      drain(9, L + 1300);

      // Reset pulse in RUN_REZ: everything clears, then a fresh commit of the held address
      @(negedge clk);
      t = cyc;
      rst = 1'b1;
      exp_out(19, 16'h0000, 0, 4'd0, 0, 0, 0, 8'd0, t + 1, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_out(20, 16'h0000, 0, 4'd5, 0, 0, 0, 8'd0, t + 1027, 0);
      exp_out(21, 16'h0020, 0, 4'd5, 1, 0, 0, 8'd0, t + 1043, 0);
      drain(10, 1300);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/uks_channel_ctrl.md
Name: uks_channel_ctrl

Overview:
- Channel controller for the 16-channel OSN/REZ distribution board.
- Debounces the 8-bit control-connector address and selects one of the 16 output points.
- Enables forward OSN/REZ data to that point only, with break-before-make guard timing.
- Monitors the point's two return lines and chooses which one (OSN main or REZ reserve) drives the upstream return, switching on loss of signal.

Parameters:
- N_CH, 16, number of output points (M1..M16).
- ADDR_W, 8, control address width.
- STABLE_CYC, 1024, cycles the synchronized address must hold before it is committed.
- GUARD_CYC, 16, all-enables-off cycles between channel changes.
- LOS_CYC, 50000, cycles without an edge that declare a return line lost (1 ms at 50 MHz).
- Counter widths are $clog2 of each count parameter.

Ports:
- clk_50_MHz  in  1  system clock from the PLL.
- rst  in  1  synchronous reset, active-high.
- addr  in  ADDR_W  raw address pins (asynchronous).
- din_osn  in  N_CH  return lines, main, one per point (asynchronous).
- din_rez  in  N_CH  return lines, reserve, one per point (asynchronous).
- dout_en  out  N_CH  one-hot forward enable; the top gates DATAIN_OSN/REZ onto DOUT_OSN/REZ[i] with it.
- ret_sel  out  1  0 = upstream return from din_osn[ch], 1 = from din_rez[ch].
- ch_sel  out  4  committed channel index.
- ch_active  out  1  1 when in RUN_OSN or RUN_REZ.
- los_osn  out  1  selected OSN return currently lost.
- los_rez  out  1  selected REZ return currently lost.
- switch_cnt  out  8  OSN<->REZ switchovers since the last channel commit; saturates at 255.

Behaviour:
- Reset: every output is 0, state is IDLE, the committed address is invalid, and all counters are 0. Reset asserted in any state returns to IDLE on the next edge and clears dout_en in the same cycle.
- Address path:
  - Two-flop synchronizer, then a stability counter. The counter clears whenever the synchronized address differs from the previous cycle.
  - When the counter reaches STABLE_CYC-1 and the address differs from the committed address, the address is committed.
  - Latency from a pin change to commit is 2+STABLE_CYC cycles.
  - Valid address: addr[7:4]==0, with the channel index taken from addr[3:0]. Any other value is invalid.
- Return path:
  - Each din line uses a two-flop synchronizer plus one extra stage; an edge is the XOR of the last two stages.
  - Only the lines of the committed channel are monitored.
  - los_* counters reset on an edge, otherwise increment and saturate at LOS_CYC. los_x = (counter==LOS_CYC).
- FSM:
  - IDLE: dout_en=0, ret_sel=0. A valid commit goes to GUARD; an invalid commit stays in IDLE.
  - GUARD: dout_en=0 for exactly GUARD_CYC cycles. ch_sel takes the new index on entry. The LOS counters and switch_cnt clear on entry. Exit goes to RUN_OSN.
  - RUN_OSN: dout_en[ch_sel]=1, ret_sel=0. If los_osn=1 and los_rez=0, go to RUN_REZ and switch_cnt+1.
  - RUN_REZ: dout_en[ch_sel]=1, ret_sel=1. If los_rez=1 and los_osn=0, go to RUN_OSN and switch_cnt+1.
  - Non-revertive: REZ is kept while it is alive, even after OSN recovers.
- Precedence, highest first: rst, then an invalid commit (go to IDLE), then a valid commit (go to GUARD), then the LOS switchover. Address and LOS events in the same cycle resolve to the address.
- Committing the same address already active never happens, because only a changed address commits, so no re-guard occurs.
- If both lines are lost, the state holds (no ping-pong) and both los flags read 1.
- dout_en is never multi-hot. Between an old and a new channel there are at least GUARD_CYC cycles with dout_en=0.
- All outputs are registered.

Test Plan:
- After rst, addr=0x05 held: commit at 2+1024 cycles, then 16 cycles with dout_en=0, then dout_en=0x0020, ch_sel=5, ret_sel=0, ch_active=1.
- Glitch: addr toggles 0x05->0x07 for 500 cycles, then back to 0x05: no commit; dout_en stays 0x0020 throughout.
- Channel 5 with din_osn[5] stuck and din_rez[5] toggling every 100 cycles: 50000 cycles after the last OSN edge, ret_sel=1, switch_cnt=1, los_osn=1. Restart OSN toggling: ret_sel stays 1. Then stop REZ: ret_sel returns to 0 and switch_cnt=2.
- Both returns on channel 5 silent: los_osn=los_rez=1, ret_sel unchanged, switch_cnt unchanged.
- addr changes 0x05->0x0C and commits in the same cycle that los_osn would trigger a switch: state goes to GUARD, switch_cnt=0, and after the guard dout_en=0x1000 with ret_sel=0.
- Invalid address and mid-run reset:
  - addr=0x35 while running: after commit, state is IDLE and dout_en=0.
  - rst pulse in RUN_REZ: all outputs 0 the next cycle, and a re-commit is needed to resume.
